// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between message producers, the TX arbiter and the downstream TX shifter.
// master: arbiter side; slave: producer/shifter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned TAG_BITS = $clog2(CHANNELS);

  logic [CHANNELS*DATA_BITS-1:0] req_data;
  logic [CHANNELS-1:0]           req_valid;
  logic [CHANNELS-1:0]           req_ready;
  logic [TAG_BITS+DATA_BITS-1:0] tx_data;
  logic                          tx_start;
  logic                          tx_busy;
  logic [TAG_BITS-1:0]           grant_id;

  modport master (
    input  req_data, req_valid, tx_busy,
    output req_ready, tx_data, tx_start, grant_id
  );

  modport slave (
    output req_data, req_valid, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding tagged {channel, data} frames to one TX shifter.
// Define UART_TX_ARBITER_FIXED_PRIO_EN for fixed priority (lowest channel index wins).
module uart_tx_arbiter #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input logic               clk,
  input logic               nrst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned TAG_BITS  = $clog2(CHANNELS);
  localparam int unsigned CAND_BITS = TAG_BITS + 1;

  typedef enum logic [1:0] {StArb, StWaitAck, StWaitDone} state_e;

  state_e                        state_q, state_d;
  logic [TAG_BITS-1:0]           ptr_q, ptr_d;
  logic [TAG_BITS-1:0]           grant_id_q, grant_id_d;
  logic [TAG_BITS+DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                          tx_start_q, tx_start_d;
  logic [TAG_BITS-1:0]           win_idx;
  logic                          win_found;
  logic                          grant;
  logic [CAND_BITS-1:0]          cand;
  logic [DATA_BITS-1:0]          words [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_words
    assign words[g] = bus.req_data[g*DATA_BITS +: DATA_BITS];
  end

  // Scan ptr, ptr+1, ... with an explicit modulo wrap so non-power-of-two CHANNELS work.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, ptr_q} + CAND_BITS'(i);
      if (cand >= CAND_BITS'(CHANNELS)) begin
        cand = cand - CAND_BITS'(CHANNELS);
      end
      if (!win_found && bus.req_valid[cand[TAG_BITS-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[TAG_BITS-1:0];
      end
    end
  end

  assign grant = nrst && (state_q == StArb) && !bus.tx_busy && win_found;

  always_comb begin
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    unique case (state_q)
      StArb: begin
        if (grant) begin
          tx_data_d  = {win_idx, words[win_idx]};
          grant_id_d = win_idx;
          tx_start_d = 1'b1;
          state_d    = StWaitAck;
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
          ptr_d      = '0;
`else
          ptr_d      = (win_idx == TAG_BITS'(CHANNELS - 1)) ? '0 : win_idx + TAG_BITS'(1);
`endif
        end
      end
      StWaitAck: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = StWaitDone;
        end
      end
      StWaitDone: begin
        // The exit cycle itself never grants; arbitration resumes next cycle.
        if (!bus.tx_busy) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.grant_id = grant_id_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART-like TX shifter link between CHANNELS independent requesters. Each accepted word is tagged with the requester's channel index, giving a frame of {tag, data}. The frame is handed to the downstream shifter with a level start/busy handshake, so the receiving side can demultiplex channels from one serial line. The block sits between on-chip message producers and the TX shifter, in the same clock domain as the shifter.

## Interface
- CHANNELS, 4, number of requesters; must be >=2.
- DATA_BITS, 8, payload width per requester; must be >=1.
- TAG_BITS (localparam), $clog2(CHANNELS), width of the channel tag.
- clk  input  1  clock; shared with the TX shifter.
- nrst  input  1  reset, synchronous, active-low.
- req_data  input  CHANNELS*DATA_BITS  payloads; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_valid  input  CHANNELS  per-channel word available; must stay high with stable data until accepted.
- req_ready  output  CHANNELS  per-channel accept; combinational, at most one bit high.
- tx_data  output  TAG_BITS+DATA_BITS  frame to shifter, {tag, data}, tag in MSBs; registered.
- tx_start  output  1  frame-start request to shifter; registered level.
- tx_busy  input  1  shifter busy; high from shifter's start acceptance to end of last stop bit.
- grant_id  output  TAG_BITS  channel of the frame currently in flight / last sent; registered.

## Operation
- FSM states: ARB, WAIT_ACK, WAIT_DONE. Reset state is ARB.
- ARB:
  - If any req_valid is high and tx_busy==0, pick winner w as the first valid channel in the order ptr, ptr+1, ..., wrapping modulo CHANNELS. The wrap is correct for non-power-of-two CHANNELS.
  - req_ready[w]=1 in that same cycle; the transfer happens on that edge.
  - On that edge: tx_data<={w[TAG_BITS-1:0], req_data[w]}, grant_id<=w, tx_start<=1, ptr<=(w+1) mod CHANNELS, go to WAIT_ACK.
  - If no valid is high, or tx_busy==1: all req_ready=0; stay in ARB.
- WAIT_ACK:
  - tx_start is held at 1 and tx_data is held stable.
  - When tx_busy==1: tx_start<=0, go to WAIT_DONE.
- WAIT_DONE:
  - When tx_busy==0, go to ARB. That cycle is still WAIT_DONE, so no grant happens in it.
- req_ready is 0 in WAIT_ACK and WAIT_DONE.
- A requester that drops req_valid before its ready cycle loses nothing: no transfer occurs and ptr is unchanged.
- ptr changes only on a grant.
- Reset values: tx_data=0, tx_start=0, grant_id=0, req_ready=0, ptr=0, state=ARB.
- Reset mid-operation:
  - Returns to ARB on the next edge with the values above.
  - A frame in WAIT_ACK is abandoned; its word was already accepted and is lost.
  - The downstream shifter is not reset by this block.

## Timing
- Grant latency: req_ready rises in the first ARB cycle in which req_valid is high and tx_busy==0, with no added register delay.
- tx_start rises 1 cycle after the grant edge. It stays high until the first cycle tx_busy is sampled high, and falls on the following edge.
- Minimum spacing between grants is 3 cycles plus the shifter busy time: grant, at least one WAIT_ACK cycle, busy period, then the WAIT_DONE exit cycle.
- Simultaneous valids: exactly one grant per frame. Round-robin guarantees each continuously valid channel a grant within CHANNELS frames.

## Configuration
- Macro: UART_TX_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins. ptr is forced to 0 and never updated. Starvation of high indices is permitted.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: req_valid=4'b0100 with data 8'hA5, tx_busy=0, and a shifter model that raises busy 1 cycle after tx_start for 12 cycles.
  - req_ready=4'b0100 for exactly 1 cycle.
  - tx_data=10'b10_1010_0101 with grant_id=2; tx_start high 1 cycle later until busy is seen.
- All four channels valid continuously, round-robin build:
  - Grant order 0,1,2,3,0,1.
  - No req_ready while tx_busy=1 or while in WAIT_ACK/WAIT_DONE.
- Same stimulus with UART_TX_ARBITER_FIXED_PRIO_EN defined: every grant goes to channel 0 while its valid stays high.
- tx_busy held high when a request arrives:
  - No req_ready until busy falls.
  - Delay the shifter ack by 5 cycles: tx_start stays high for all 5 cycles with tx_data stable.
- nrst=0 asserted during WAIT_ACK:
  - Next cycle tx_start=0, tx_data=0, grant_id=0, req_ready=0.
  - After release, a channel-3-only request is granted normally, and a subsequent all-valid round starts at channel 0.
- Channel 1 drops req_valid while a channel-0 frame is in flight: channel 1 is never granted and ptr does not advance past it spuriously.
